// File: rtl/seg7_pkg.sv
// Shared constants for the cursor-driven seven-segment display: blank pattern,
// editable digit count, cursor sentinel, scan index encoding and hex glyph table.
package seg7_pkg;

    localparam logic [6:0]  SEG_BLANK       = 7'b1111111;
    localparam int unsigned NUM_EDIT_DIGITS = 3;
    localparam logic [1:0]  CUR_NONE        = 2'd3;

    typedef enum logic [1:0] {
        SCAN_D0 = 2'd0,
        SCAN_D1 = 2'd1,
        SCAN_D2 = 2'd2,
        SCAN_D3 = 2'd3
    } scan_idx_t;

    // Active-low {g,f,e,d,c,b,a} glyphs for 0..F
    localparam logic [6:0] HEX7 [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    function automatic logic [3:0] anode_for(input scan_idx_t idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational nibble to active-low seven-segment pattern lookup.
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = HEX7[nib_i];
    end

endmodule

// File: rtl/seven_seg_cursor_display.sv
// Three editable hex digits written at the synchronized cursor on each load edge,
// shown on a multiplexed 4-digit display with a blinking cursor digit and cursor index on digit 3.
module seven_seg_cursor_display
    import seg7_pkg::*;
#(
    parameter int unsigned SCAN_DIV  = 100_000,
    parameter int unsigned BLINK_DIV = 50_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sel_1,
    input  logic        sel_2,
    input  logic        load,
    input  logic [3:0]  din,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [11:0] value,
    output logic        wr_pulse
);

    localparam int unsigned SCAN_W  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
    localparam int unsigned BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

    logic        load_m_q, load_s_q, load_d_q;
    logic [1:0]  sel_m_q, sel_s_q;
    logic        wr_en;

    logic [11:0] value_q, value_d;
    logic        wr_pulse_q;

    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               blink_on_q, blink_on_d;

    logic [SCAN_W-1:0]  scan_cnt_q, scan_cnt_d;
    scan_idx_t          scan_idx_q, scan_idx_d;

    logic [3:0]  disp_nib;
    logic [6:0]  glyph;
    logic [3:0]  an_q, an_d;
    logic [6:0]  seg_q, seg_d;
    logic        dp_q, dp_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load_m_q <= 1'b0;
            load_s_q <= 1'b0;
            load_d_q <= 1'b0;
            sel_m_q  <= '0;
            sel_s_q  <= '0;
        end else begin
            load_m_q <= load;
            load_s_q <= load_m_q;
            load_d_q <= load_s_q;
            sel_m_q  <= {sel_1, sel_2};
            sel_s_q  <= sel_m_q;
        end
    end

    assign wr_en = load_s_q && !load_d_q && (sel_s_q != CUR_NONE);

    always_comb begin
        value_d = value_q;
        if (wr_en) begin
            case (sel_s_q)
                2'd0:    value_d[3:0]  = din;
                2'd1:    value_d[7:4]  = din;
                2'd2:    value_d[11:8] = din;
                default: value_d       = value_q;
            endcase
        end
    end

    // A write restarts the blink phase so the freshly entered digit is visible at once.
    always_comb begin
        blink_cnt_d = blink_cnt_q + 1'b1;
        blink_on_d  = blink_on_q;
        if (wr_en) begin
            blink_cnt_d = '0;
            blink_on_d  = 1'b1;
        end else if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            blink_on_d  = !blink_on_q;
        end
    end

    always_comb begin
        scan_cnt_d = scan_cnt_q + 1'b1;
        scan_idx_d = scan_idx_q;
        if (scan_cnt_q == SCAN_LAST) begin
            scan_cnt_d = '0;
            scan_idx_d = scan_idx_t'(2'(scan_idx_q) + 2'd1);
        end
    end

    always_comb begin
        disp_nib = {2'b00, sel_s_q};
        dp_d     = 1'b1;
        case (scan_idx_q)
            SCAN_D0: disp_nib = value_q[3:0];
            SCAN_D1: disp_nib = value_q[7:4];
            SCAN_D2: disp_nib = value_q[11:8];
            default: dp_d     = 1'b0;
        endcase
    end

    hex_to_seg7 u_hex_to_seg7 (
        .nib_i (disp_nib),
        .seg_o (glyph)
    );

    // Digit 3 never matches a cursor below CUR_NONE, so only editable digits can blank.
    always_comb begin
        an_d  = anode_for(scan_idx_q);
        seg_d = glyph;
        if ((scan_idx_q != SCAN_D3) && (2'(scan_idx_q) == sel_s_q) && !blink_on_q) begin
            seg_d = SEG_BLANK;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_q     <= '0;
            wr_pulse_q  <= 1'b0;
            blink_cnt_q <= '0;
            blink_on_q  <= 1'b1;
            scan_cnt_q  <= '0;
            scan_idx_q  <= SCAN_D0;
            an_q        <= '1;
            seg_q       <= SEG_BLANK;
            dp_q        <= 1'b1;
        end else begin
            value_q     <= value_d;
            wr_pulse_q  <= wr_en;
            blink_cnt_q <= blink_cnt_d;
            blink_on_q  <= blink_on_d;
            scan_cnt_q  <= scan_cnt_d;
            scan_idx_q  <= scan_idx_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
        end
    end

    assign an       = an_q;
    assign seg      = seg_q;
    assign dp       = dp_q;
    assign value    = value_q;
    assign wr_pulse = wr_pulse_q;

endmodule

// File: tb/tb_seven_seg_cursor_display.sv
// Directed bench for seven_seg_cursor_display: write vector table plus hand-timed
// reset, blink and held-load sequences; all timing is counted in clk edges from reset release.
module tb_seven_seg_cursor_display;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel_1, sel_2, load;
    logic [3:0]  din;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic [11:0] value;
    logic        wr_pulse;

    int n_checks = 0;
    int n_fail   = 0;

    logic [6:0] hex_ref [16];

    typedef struct {
        logic [1:0]  sel;
        logic [3:0]  din;
        int          exp_wr;
        logic [11:0] exp_val;
    } vec_t;

    vec_t vecs [5];

    seven_seg_cursor_display #(
        .SCAN_DIV  (4),
        .BLINK_DIV (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .sel_1    (sel_1),
        .sel_2    (sel_2),
        .load     (load),
        .din      (din),
        .an       (an),
        .seg      (seg),
        .dp       (dp),
        .value    (value),
        .wr_pulse (wr_pulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Expects an unblanked display of the given digits and cursor index.
    task automatic check_disp(input string tag, input logic [11:0] v, input logic [1:0] cur);
        logic [3:0] nib;
        logic       exp_dp;
        exp_dp = 1'b1;
        case (an)
            4'b1110: nib = v[3:0];
            4'b1101: nib = v[7:4];
            4'b1011: nib = v[11:8];
            4'b0111: begin nib = {2'b00, cur}; exp_dp = 1'b0; end
            default: begin
                nib = 4'h0;
                check({tag, " an_onehot"}, {8'h0, an}, 12'he);
            end
        endcase
        check({tag, " seg"}, {5'h0, seg}, {5'h0, hex_ref[nib]});
        check({tag, " dp"}, {11'h0, dp}, {11'h0, exp_dp});
    endtask

    initial begin
        int pulses;
        int first;

        hex_ref = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

        vecs[0] = '{sel: 2'b01, din: 4'h5, exp_wr: 1, exp_val: 12'h05A};
        vecs[1] = '{sel: 2'b11, din: 4'hF, exp_wr: 0, exp_val: 12'h05A};
        vecs[2] = '{sel: 2'b00, din: 4'h3, exp_wr: 1, exp_val: 12'h053};
        vecs[3] = '{sel: 2'b01, din: 4'hC, exp_wr: 1, exp_val: 12'h0C3};
        vecs[4] = '{sel: 2'b10, din: 4'h8, exp_wr: 1, exp_val: 12'h8C3};

        rst = 1'b1; sel_1 = 1'b0; sel_2 = 1'b0; load = 1'b0; din = 4'h0;
        repeat (2) step();
        check("rst an",    {8'h0, an},        12'hF);
        check("rst seg",   {5'h0, seg},       12'h7F);
        check("rst dp",    {11'h0, dp},       12'h1);
        check("rst value", value,             12'h000);
        check("rst wr",    {11'h0, wr_pulse}, 12'h0);

        // First release: n counts posedges since release
        rst = 1'b0;
        step();  // n=1
        check("rel1 an n1",  {8'h0, an},  12'hE);
        check("rel1 seg n1", {5'h0, seg}, {5'h0, 7'b1000000});
        check("rel1 dp n1",  {11'h0, dp}, 12'h1);
        repeat (4) step();  // n=5
        check("rel1 an n5",  {8'h0, an},  12'hD);
        check("rel1 seg n5", {5'h0, seg}, {5'h0, 7'b1000000});
        repeat (8) step();  // n=13
        check("rel1 an n13",  {8'h0, an},  12'h7);
        check("rel1 seg n13", {5'h0, seg}, {5'h0, 7'b1000000});
        check("rel1 dp n13",  {11'h0, dp}, 12'h0);
        repeat (5) step();  // n=18, blink off phase
        check("blink off an",  {8'h0, an},  12'hE);
        check("blink off seg", {5'h0, seg}, 12'h7F);
        repeat (3) step();  // n=21
        check("blink off other an",  {8'h0, an},  12'hD);
        check("blink off other seg", {5'h0, seg}, {5'h0, 7'b1000000});

        // Asynchronous reset between clock edges
        step();
        #2 rst = 1'b1;
        #1;
        check("midrst an",    {8'h0, an},        12'hF);
        check("midrst seg",   {5'h0, seg},       12'h7F);
        check("midrst dp",    {11'h0, dp},       12'h1);
        check("midrst value", value,             12'h000);
        check("midrst wr",    {11'h0, wr_pulse}, 12'h0);
        repeat (2) step();
        rst = 1'b0;

        // Second release: write A into digit0 during its off phase
        step();  // n=1
        check("rel2 an n1", {8'h0, an}, 12'hE);
        repeat (16) step();  // n=17
        check("offwr pre an",  {8'h0, an},  12'hE);
        check("offwr pre seg", {5'h0, seg}, 12'h7F);
        din = 4'hA; load = 1'b1;
        step();  // n=18
        check("offwr wr n18", {11'h0, wr_pulse}, 12'h0);
        step();  // n=19
        check("offwr wr n19", {11'h0, wr_pulse}, 12'h0);
        step();  // n=20
        check("offwr wr n20",    {11'h0, wr_pulse}, 12'h1);
        check("offwr value n20", value,             12'h00A);
        step();  // n=21
        check("offwr wr n21", {11'h0, wr_pulse}, 12'h0);
        load = 1'b0;
        repeat (12) step();  // n=33
        check("offwr post an",  {8'h0, an},  12'hE);
        check("offwr post seg", {5'h0, seg}, {5'h0, 7'b0001000});
        check("offwr post dp",  {11'h0, dp}, 12'h1);

        for (int v = 0; v < 5; v++) begin
            {sel_1, sel_2} = vecs[v].sel;
            din = vecs[v].din;
            repeat (3) step();
            load = 1'b1;
            pulses = 0;
            first = 0;
            for (int i = 1; i <= 19; i++) begin
                step();
                if (i == 11) load = 1'b0;
                if (wr_pulse) begin
                    pulses++;
                    if (first == 0) first = i;
                end
                if (i >= 4) check_disp($sformatf("vec%0d disp", v), vecs[v].exp_val, vecs[v].sel);
            end
            check($sformatf("vec%0d pulses", v), 12'(pulses), 12'(vecs[v].exp_wr));
            check($sformatf("vec%0d latency", v), 12'(first), (vecs[v].exp_wr != 0) ? 12'd3 : 12'd0);
            check($sformatf("vec%0d value", v), value, vecs[v].exp_val);
            if (vecs[v].sel == 2'b11) begin
                for (int j = 0; j < 128; j++) begin
                    step();
                    check_disp("curnone disp", vecs[v].exp_val, 2'b11);
                    check("curnone wr", {11'h0, wr_pulse}, 12'h0);
                end
            end
            repeat (4) step();
        end

        // Held load: cursor moves after the edge, only the sampled cursor is written
        {sel_1, sel_2} = 2'b00;
        din = 4'h7;
        repeat (3) step();
        load = 1'b1;
        pulses = 0;
        step();
        if (wr_pulse) pulses++;
        {sel_1, sel_2} = 2'b01;
        for (int i = 0; i < 99; i++) begin
            step();
            if (wr_pulse) pulses++;
        end
        load = 1'b0;
        repeat (4) begin
            step();
            if (wr_pulse) pulses++;
        end
        check("held pulses", 12'(pulses), 12'd1);
        check("held value",  value,       12'h8C7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seven_seg_cursor_display.md
Name: seven_seg_cursor_display

Overview:
- Consumer side of the button control unit's `{sel_1,sel_2}` cursor and `load` interface.
- Holds a 3-digit hex value and writes switch data `din` into the digit under the cursor on each `load` rising edge.
- Drives the Basys3 4-digit seven-segment display, time-multiplexed.
- The cursor digit blinks; digit 3 shows the cursor index.

Parameters:
- SCAN_DIV, 100_000: clk cycles per digit scan step (1 kHz per digit at 100 MHz).
- BLINK_DIV, 50_000_000: clk cycles per blink half-period.
- Bench overrides: SCAN_DIV=4, BLINK_DIV=16.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- sel_1  in  1  cursor MSB (cursor = {sel_1,sel_2}).
- sel_2  in  1  cursor LSB.
- load  in  1  write request, level from the slow clock domain; rising edge = one write.
- din  in  4  hex nibble from the switches.
- an  out  4  digit anodes, active low, an[0] = rightmost.
- seg  out  7  segments {g,f,e,d,c,b,a}, active low.
- dp  out  1  decimal point, active low.
- value  out  12  {digit2,digit1,digit0} register contents.
- wr_pulse  out  1  one-cycle strobe; digit written this cycle.

Behaviour:
- Reset (async, immediate, including mid-scan or mid-write):
  - digit0..2 = 0; value = 0.
  - an = 4'b1111, seg = 7'b1111111, dp = 1.
  - scan_idx = 0, scan_cnt = 0, blink_cnt = 0, blink_on = 1.
  - wr_pulse = 0; synchronizer flops = 0.
- Input capture: load, sel_1, sel_2 each pass through 2-flop synchronizers. Edge detect is load_s & ~load_d.
- Write:
  - Condition: edge detected AND cursor_s < 3. Action: digit[cursor_s] <= din at that clk edge, wr_pulse = 1 for that one cycle.
  - Latency: load rising before clk edge k gives digit/value updated and wr_pulse high after edge k+2.
  - load held high: exactly one write. A new write needs load low for at least one synced cycle.
  - cursor_s == 3: no write, no wr_pulse, and no digit blinks.
  - din 0xA..0xF: stored and displayed as hex A-F.
  - Every write restarts blink: blink_cnt <= 0, blink_on <= 1.
- Blink: blink_cnt counts 0..BLINK_DIV-1. At the terminal count it wraps to 0 and blink_on toggles.
- Scan:
  - scan_cnt counts 0..SCAN_DIV-1. At the terminal count it wraps and scan_idx advances 0→1→2→3→0.
  - an/seg/dp are registered from the current scan_idx: one-cycle pipeline, only one anode low at a time.
  - The first anode drives low one cycle after reset release.
- Per digit index i:
  - i in 0..2: seg = hex7(digit[i]), dp = 1. If i == cursor_s and blink_on == 0: seg = 7'b1111111 (anode still low).
  - i = 3: seg = hex7({2'b00,cursor_s}), dp = 0.
- hex7 encoding, {g..a} active low:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Simultaneous events:
  - Write and scan step in the same cycle: display reflects the new digit from the next register update.
  - Write and blink terminal count in the same cycle: write wins, blink_on = 1.
- Counter widths: $clog2 of the divider. No overflow beyond the terminal count.

Decomposition:
- Package seg7_pkg:
  - SEG_BLANK = 7'b1111111.
  - NUM_EDIT_DIGITS = 3.
  - CUR_NONE = 2'd3.
  - 16-entry hex7 constant table.
- Sub-module hex_to_seg7: combinational nibble → 7-bit active-low pattern.
  - Instantiated once, after the digit mux.

Test Plan:
- Reset mid-scan:
  - Stimulus: assert rst at an arbitrary cycle.
  - Response: an=1111, seg=1111111, dp=1, value=0 in the same cycle (async); first an=1110 one clk after release.
- Single write:
  - Stimulus: sel=01, din=5, pulse load for 10 cycles.
  - Response: exactly one wr_pulse, 3 edges after load rise; value=12'h050.
  - Response: digit1 anode (an=1101) shows seg=0010010.
- Cursor none:
  - Stimulus: sel=11, din=F, load pulse.
  - Response: no wr_pulse, value unchanged; digit3 shows 0110000 with dp=0; no digit blanks over 4 blink periods.
- Blink and restart:
  - Stimulus: sel=00, idle 16 cycles.
  - Response: digit0 seg=1111111 while an=1110 during the off phase.
  - Stimulus: write din=A during the off phase.
  - Response: digit0 shows 0001000 immediately; blink_on=1 for 16 cycles.
- Full fill and hex:
  - Stimulus: writes (sel,din) = (00,3), (01,C), (10,8).
  - Response: value=12'h8C3; the scan cycle shows 0110000, 1000110, 0000000 on an=1110, 1101, 1011.
- Held load:
  - Stimulus: load high for 100 cycles while sel changes 00→01.
  - Response: one write only, to the cursor sampled at the edge.
